// File: rtl/parking_gate_ctrl.sv
// Entry/exit gate controller for a mixed car/bike car park.
// Two independent gate FSMs admit vehicles against capacity and emit single-cycle occupancy events.

module parking_gate_fsm #(
    parameter int unsigned GATE_TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor,
    input  logic is_bike,
    input  logic pass,
    input  logic car_ok,
    input  logic bike_ok,
    output logic in_idle,
    output logic gate_open,
    output logic car_pulse,
    output logic bike_pulse
);

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        CLEAR
    } gate_state_t;

    localparam logic [7:0] TIMER_LAST = 8'(GATE_TIMEOUT - 1);

    gate_state_t state, state_next;
    logic [7:0]  timer, timer_next;
    logic        bike_latched, bike_latched_next;
    logic        gate_next, car_pulse_next, bike_pulse_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            bike_latched <= 1'b0;
            gate_open    <= 1'b0;
            car_pulse    <= 1'b0;
            bike_pulse   <= 1'b0;
        end else begin
            state        <= state_next;
            timer        <= timer_next;
            bike_latched <= bike_latched_next;
            gate_open    <= gate_next;
            car_pulse    <= car_pulse_next;
            bike_pulse   <= bike_pulse_next;
        end
    end

    always_comb begin
        state_next        = state;
        timer_next        = '0;
        bike_latched_next = bike_latched;
        car_pulse_next    = 1'b0;
        bike_pulse_next   = 1'b0;

        case (state)
            IDLE: begin
                if (sensor && (is_bike ? bike_ok : car_ok)) begin
                    state_next        = OPEN;
                    bike_latched_next = is_bike;
                end
            end
            OPEN: begin
                // pass is checked before the timeout so a crossing on the last cycle still counts
                if (pass) begin
                    state_next      = CLEAR;
                    car_pulse_next  = !bike_latched;
                    bike_pulse_next = bike_latched;
                end else if (timer == TIMER_LAST) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer + 8'd1;
                end
            end
            CLEAR: begin
                if (!sensor) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        gate_next = (state_next == OPEN);
    end

    assign in_idle = (state == IDLE);

endmodule

module parking_gate_ctrl #(
    parameter logic [7:0]  CAR_CAP      = 8'd50,
    parameter logic [7:0]  BIKE_CAP     = 8'd100,
    parameter int unsigned GATE_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       entry_sensor,
    input  logic       entry_is_bike,
    input  logic       entry_pass,
    input  logic       exit_sensor,
    input  logic       exit_is_bike,
    input  logic       exit_pass,
    input  logic [7:0] cars_in_parking,
    input  logic [7:0] bikes_in_parking,
    output logic       car_entry,
    output logic       bike_entry,
    output logic       car_exit,
    output logic       bike_exit,
    output logic       entry_gate_open,
    output logic       exit_gate_open,
    output logic       car_full,
    output logic       bike_full,
    output logic       entry_denied
);

    logic entry_idle;
    logic exit_idle;
    logic entry_car_ok, entry_bike_ok;
    logic exit_car_ok, exit_bike_ok;

    assign car_full  = (cars_in_parking >= CAR_CAP);
    assign bike_full = (bikes_in_parking >= BIKE_CAP);

    assign entry_car_ok  = !car_full;
    assign entry_bike_ok = !bike_full;
    assign exit_car_ok   = (cars_in_parking != '0);
    assign exit_bike_ok  = (bikes_in_parking != '0);

    assign entry_denied = entry_idle && entry_sensor && (entry_is_bike ? bike_full : car_full);

    parking_gate_fsm #(
        .GATE_TIMEOUT(GATE_TIMEOUT)
    ) u_entry (
        .clk       (clk),
        .rst_n     (rst_n),
        .sensor    (entry_sensor),
        .is_bike   (entry_is_bike),
        .pass      (entry_pass),
        .car_ok    (entry_car_ok),
        .bike_ok   (entry_bike_ok),
        .in_idle   (entry_idle),
        .gate_open (entry_gate_open),
        .car_pulse (car_entry),
        .bike_pulse(bike_entry)
    );

    parking_gate_fsm #(
        .GATE_TIMEOUT(GATE_TIMEOUT)
    ) u_exit (
        .clk       (clk),
        .rst_n     (rst_n),
        .sensor    (exit_sensor),
        .is_bike   (exit_is_bike),
        .pass      (exit_pass),
        .car_ok    (exit_car_ok),
        .bike_ok   (exit_bike_ok),
        .in_idle   (exit_idle),
        .gate_open (exit_gate_open),
        .car_pulse (car_exit),
        .bike_pulse(bike_exit)
    );

    // exit_idle has no consumer at the top; it exists for symmetry with the entry side
    logic unused_exit_idle;
    assign unused_exit_idle = exit_idle;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: directed scenarios then randomized traffic
// compared against a per-gate phase model driven by the same inputs.

module tb_parking_gate_ctrl;

    localparam logic [7:0]  CAR_CAP  = 8'd50;
    localparam logic [7:0]  BIKE_CAP = 8'd100;
    localparam int unsigned TO       = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       entry_sensor = 1'b0, entry_is_bike = 1'b0, entry_pass = 1'b0;
    logic       exit_sensor = 1'b0, exit_is_bike = 1'b0, exit_pass = 1'b0;
    logic [7:0] cars = 8'd0, bikes = 8'd0;
    logic       car_entry, bike_entry, car_exit, bike_exit;
    logic       entry_gate_open, exit_gate_open;
    logic       car_full, bike_full, entry_denied;

    int checks = 0;
    int errors = 0;
    bit auto_occ = 1'b0;

    // Model per gate (0 = entry, 1 = exit): phase 0 waiting, 1 gate up, 2 waiting for sensor to drop
    int ph[2];
    int open_cycles[2];
    bit ty_bike[2];
    bit e_gate[2], e_car[2], e_bike[2];

    parking_gate_ctrl #(
        .CAR_CAP     (CAR_CAP),
        .BIKE_CAP    (BIKE_CAP),
        .GATE_TIMEOUT(TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .entry_sensor    (entry_sensor),
        .entry_is_bike   (entry_is_bike),
        .entry_pass      (entry_pass),
        .exit_sensor     (exit_sensor),
        .exit_is_bike    (exit_is_bike),
        .exit_pass       (exit_pass),
        .cars_in_parking (cars),
        .bikes_in_parking(bikes),
        .car_entry       (car_entry),
        .bike_entry      (bike_entry),
        .car_exit        (car_exit),
        .bike_exit       (bike_exit),
        .entry_gate_open (entry_gate_open),
        .exit_gate_open  (exit_gate_open),
        .car_full        (car_full),
        .bike_full       (bike_full),
        .entry_denied    (entry_denied)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            ph[g] = 0; open_cycles[g] = 0; ty_bike[g] = 1'b0;
            e_gate[g] = 1'b0; e_car[g] = 1'b0; e_bike[g] = 1'b0;
        end
    endtask

    task automatic model_step(input int g, input bit sensor, input bit isb, input bit pass,
                              input bit can_car, input bit can_bike);
        e_car[g]  = 1'b0;
        e_bike[g] = 1'b0;
        if (ph[g] == 0) begin
            if (sensor && (isb ? can_bike : can_car)) begin
                ph[g] = 1; open_cycles[g] = 1; ty_bike[g] = isb;
            end
        end else if (ph[g] == 1) begin
            if (pass) begin
                ph[g] = 2;
                if (ty_bike[g]) e_bike[g] = 1'b1; else e_car[g] = 1'b1;
            end else if (open_cycles[g] == int'(TO)) begin
                ph[g] = 0;
            end else begin
                open_cycles[g]++;
            end
        end else if (!sensor) begin
            ph[g] = 0;
        end
        e_gate[g] = (ph[g] == 1);
    endtask

    task automatic check_regs(input string when);
        chk({when, ".entry_gate"}, entry_gate_open, e_gate[0]);
        chk({when, ".exit_gate"},  exit_gate_open,  e_gate[1]);
        chk({when, ".car_entry"},  car_entry,       e_car[0]);
        chk({when, ".bike_entry"}, bike_entry,      e_bike[0]);
        chk({when, ".car_exit"},   car_exit,        e_car[1]);
        chk({when, ".bike_exit"},  bike_exit,       e_bike[1]);
    endtask

    // Drive one cycle of inputs, check combinational flags, clock once, check registered outputs.
    task automatic apply(input bit es, input bit eib, input bit ep,
                         input bit xs, input bit xib, input bit xp);
        bit cf, bf, den;
        entry_sensor = es; entry_is_bike = eib; entry_pass = ep;
        exit_sensor  = xs; exit_is_bike  = xib; exit_pass  = xp;
        #1;
        cf  = (int'(cars) >= int'(CAR_CAP));
        bf  = (int'(bikes) >= int'(BIKE_CAP));
        den = (ph[0] == 0) && es && (eib ? bf : cf);
        chk("car_full", car_full, cf);
        chk("bike_full", bike_full, bf);
        chk("entry_denied", entry_denied, den);
        model_step(0, es, eib, ep, !cf, !bf);
        model_step(1, xs, xib, xp, cars != 8'd0, bikes != 8'd0);
        @(posedge clk);
        #1;
        check_regs("cyc");
        if (auto_occ) begin
            if (e_car[0] && cars != 8'd255) cars++;
            if (e_bike[0] && bikes != 8'd255) bikes++;
            if (e_car[1] && cars != 8'd0) cars--;
            if (e_bike[1] && bikes != 8'd0) bikes--;
        end
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1 check_regs("por");
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Car admitted, crosses on the third edge
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 0, 1, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);

        // Car park full for cars, bikes still admitted; then the bike gate times out
        cars = 8'd50;
        repeat (3) apply(1, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 0, 0, 0);
        repeat (TO + 1) apply(0, 1, 0, 0, 0, 0);

        // Crossing on the last open cycle still produces a pulse
        cars = 8'd0;
        apply(1, 0, 0, 0, 0, 0);
        repeat (TO - 1) apply(0, 0, 0, 0, 0, 0);
        apply(0, 0, 1, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);

        // Simultaneous bike entry and car exit
        cars = 8'd5; bikes = 8'd0;
        apply(1, 1, 0, 1, 0, 0);
        apply(1, 1, 1, 1, 0, 1);
        apply(0, 0, 0, 0, 0, 0);

        // Bike exit requested with no bikes inside
        repeat (4) apply(0, 0, 0, 1, 1, 0);
        apply(0, 0, 0, 0, 0, 0);

        // Saturated occupancy reads full
        cars = 8'd255; bikes = 8'd255;
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 1, 0, 0, 0, 0);
        cars = 8'd0; bikes = 8'd0;
        apply(0, 0, 0, 0, 0, 0);

        // Reset while entry gate open, sensor held through release
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_regs("async_rst");
        @(posedge clk);
        #1 check_regs("in_rst");
        #2 rst_n = 1'b1;
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 0, 1, 0, 0, 0);
        repeat (3) apply(1, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);

        // Randomized traffic with occupancy tracked from the expected pulses
        auto_occ = 1'b1;
        cars  = 8'(48);
        bikes = 8'(98);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) cars  = ($urandom_range(0, 1) != 0) ? 8'd0 : 8'(CAR_CAP);
            if ($urandom_range(0, 49) == 0) bikes = ($urandom_range(0, 1) != 0) ? 8'd0 : 8'(BIKE_CAP);
            apply($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 Parameter CAR_CAP, default 8'd50: maximum cars allowed inside.
REQ-002 Parameter BIKE_CAP, default 8'd100: maximum bikes allowed inside.
REQ-003 Parameter GATE_TIMEOUT, default 8: cycles a gate stays open waiting for passage (range 2..255).
REQ-004 clk  in  1  single system clock; all state changes on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 entry_sensor  in  1  vehicle waiting at entry gate (level).
REQ-007 entry_is_bike  in  1  type of waiting entry vehicle (1 = bike, 0 = car).
REQ-008 entry_pass  in  1  vehicle has crossed the entry gate line.
REQ-009 exit_sensor, exit_is_bike, exit_pass  in  1 each  same meanings for the exit gate.
REQ-010 cars_in_parking, bikes_in_parking  in  8 each  occupancy fed back from the downstream counter.
REQ-011 car_entry, bike_entry, car_exit, bike_exit  out  1 each  single-cycle registered event pulses to the downstream counter.
REQ-012 entry_gate_open, exit_gate_open  out  1 each  registered gate actuator commands.
REQ-013 car_full, bike_full  out  1 each  combinational: occupancy >= CAR_CAP / BIKE_CAP.
REQ-014 entry_denied  out  1  combinational: entry FSM in IDLE, entry_sensor=1 and the full flag for entry_is_bike's type is 1.

Function
REQ-015 Entry and exit FSMs SHALL be independent, each with states IDLE, OPEN, CLEAR.
REQ-016 Entry IDLE->OPEN when entry_sensor=1 and the matching full flag=0; vehicle type latched at this edge; entry_is_bike ignored thereafter until back in IDLE.
REQ-017 Entry gate open SHALL assert in the cycle after the IDLE->OPEN edge (1-cycle latency) and remain high for all of OPEN.
REQ-018 In OPEN, a per-gate timer SHALL start at 0 on entry and increment each cycle.
REQ-019 OPEN->CLEAR when entry_pass=1: exactly one pulse on car_entry or bike_entry (per latched type) in the following cycle; gate closes at the same edge.
REQ-020 OPEN->IDLE with no pulse when timer reaches GATE_TIMEOUT-1 and entry_pass=0; entry_pass=1 in that same cycle takes priority (pass wins).
REQ-021 CLEAR->IDLE when entry_sensor=0; gate stays closed; a sensor held high SHALL NOT cause a second admission.
REQ-022 Exit FSM SHALL mirror REQ-016..021 using exit_* inputs, with the open condition being occupancy of the latched type > 0 (no exit gate opening for an empty class); pulses on car_exit / bike_exit.
REQ-023 Entry and exit pulses SHALL be permitted in the same cycle; at most one entry pulse and one exit pulse per cycle.
REQ-024 Capacity SHALL be evaluated only at the IDLE sampling edge; occupancy change while OPEN does not abort.
REQ-025 The CLEAR state guarantees >=1 cycle between pulses so the downstream counter updates before the next capacity check.
REQ-026 All comparisons unsigned 8-bit; occupancy 8'd255 with CAP 255 SHALL read full.

Reset
REQ-027 rst_n=0 SHALL immediately force both FSMs to IDLE, timers to 0, all pulse and gate outputs to 0, independent of clk.
REQ-028 Reset mid-OPEN SHALL drop the gate with no pulse; after release, first admission needs a fresh IDLE sample.
REQ-029 Outputs SHALL leave reset values only on the first rising clk edge with rst_n=1.

Verification
REQ-030 Occupancy 0, entry_sensor=1, is_bike=0 at edge 1, entry_pass=1 at edge 3 -> gate high cycles 2-3, car_entry single pulse cycle 4, gate low cycle 4.
REQ-031 cars_in_parking=50 (CAP 50), entry_sensor=1 car -> entry_denied=1, gate never opens; bike request at same time with bikes=0 -> admitted.
REQ-032 Gate opened, no entry_pass for 8 cycles -> gate closes after 8 open cycles, no pulse; entry_pass on cycle 8 -> pulse instead.
REQ-033 Simultaneous entry_pass (bike) and exit_pass (car, cars=5) -> bike_entry and car_exit pulse same cycle.
REQ-034 exit_sensor=1, exit_is_bike=1, bikes_in_parking=0 -> exit gate stays closed, no bike_exit.
REQ-035 rst_n low while entry gate open -> entry_gate_open=0 immediately; sensor held high through release -> reopens one cycle after first post-reset edge, single pulse per pass.
